// File: rtl/pid_scheduler.sv
// pid_scheduler
// Runs a shared, time-multiplexed 10-state discrete PID core (E1..E10) once
// per enabled channel on every accepted control-loop tick. Channel errors and
// the enable mask are snapshotted at the tick so the sweep sees a coherent set.
//
// Ports
//   clk_pid      clock, shared with the PID core
//   reset        synchronous, active-high
//   tick         control-loop strobe, accepted only in IDLE
//   ch_enable    per-channel enable mask (AN bits)
//   error_flat   signed errors, channel i at [i*EW +: EW]
//   pid_a        channel address to the core
//   pid_ce       clock enable to the core
//   pid_reset    core reset (effective only with pid_ce)
//   pid_error    error slice of the snapshot at pid_a
//   pid_m_k      motor output from the core
//   m_k_flat     captured outputs, channel i at [i*OW +: OW]
//   m_k_valid    one-cycle per-channel update pulse
//   busy         high in SCAN and RUN
//   done         one-cycle end-of-sweep pulse
//   overrun_cnt  saturating count of ticks rejected while a sweep is active
//
// state | meaning
// INIT0 | core clocked with reset -> core forced to E0
// INIT1 | core clocked once       -> core parked at E1
// IDLE  | waiting for a tick
// SCAN  | looking for the next enabled channel (1 cycle per index)
// RUN   | 10 core-enabled steps for channel idx (E1..E10, back to E1)
// DONE  | done pulse, then back to IDLE
module pid_scheduler #(
   parameter  int AW  = 1,
   parameter  int EW  = 24,
   parameter  int OW  = 12,
   parameter  int OVW = 8,
   localparam int AN  = 2 ** AW
) (
   input  logic              clk_pid,
   input  logic              reset,
   input  logic              tick,
   input  logic [AN-1:0]     ch_enable,
   input  logic [AN*EW-1:0]  error_flat,
   output logic [AW-1:0]     pid_a,
   output logic              pid_ce,
   output logic              pid_reset,
   output logic [EW-1:0]     pid_error,
   input  logic [OW-1:0]     pid_m_k,
   output logic [AN*OW-1:0]  m_k_flat,
   output logic [AN-1:0]     m_k_valid,
   output logic              busy,
   output logic              done,
   output logic [OVW-1:0]    overrun_cnt
);

   typedef enum logic [2:0] {
      S_INIT0,
      S_INIT1,
      S_IDLE,
      S_SCAN,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [AW-1:0] IDX_LAST  = AW'(AN - 1);
   localparam logic [3:0]    STEP_LAST = 4'd9;

   state_t             state;
   logic [AW-1:0]      idx;
   logic [3:0]         step;
   logic [AN*EW-1:0]   err_snap;
   logic [AN-1:0]      mask_snap;

   assign pid_error = err_snap[int'(pid_a)*EW +: EW];

   // Outputs are registered alongside the state, so each one is assigned on
   // the transition into the state where it must hold its value.
   always_ff @(posedge clk_pid) begin
      if (reset) begin
         state       <= S_INIT0;
         idx         <= '0;
         step        <= '0;
         err_snap    <= '0;
         mask_snap   <= '0;
         pid_a       <= '0;
         pid_ce      <= 1'b1;
         pid_reset   <= 1'b1;
         m_k_flat    <= '0;
         m_k_valid   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         m_k_valid <= '0;
         done      <= 1'b0;

         if (tick && (state inside {S_SCAN, S_RUN, S_DONE}) && (overrun_cnt != '1))
            overrun_cnt <= overrun_cnt + 1'b1;

         case (state)
            S_INIT0: begin
               state     <= S_INIT1;
               pid_ce    <= 1'b1;
               pid_reset <= 1'b0;
            end
            S_INIT1: begin
               state  <= S_IDLE;
               pid_ce <= 1'b0;
            end
            S_IDLE: begin
               if (tick) begin
                  err_snap  <= error_flat;
                  mask_snap <= ch_enable;
                  idx       <= '0;
                  busy      <= 1'b1;
                  state     <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (mask_snap[idx]) begin
                  step   <= '0;
                  pid_a  <= idx;
                  pid_ce <= 1'b1;
                  state  <= S_RUN;
               end else if (idx == IDX_LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_RUN: begin
               if (step == STEP_LAST) begin
                  // Core wrote m_k at the end of step 8; it is stable now.
                  m_k_flat[int'(idx)*OW +: OW] <= pid_m_k;
                  m_k_valid[idx]               <= 1'b1;
                  pid_ce                       <= 1'b0;
                  if (idx == IDX_LAST) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= S_SCAN;
                  end
               end else begin
                  step <= step + 4'd1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state     <= S_INIT0;
               pid_ce    <= 1'b1;
               pid_reset <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pid_scheduler.sv
// tb_pid_scheduler
// Directed bench for pid_scheduler with a behavioural 10-state PID core.
// Core law: m_k = m_{k-1} + 3*e_k - e_{k-1}, per channel, latched e in E1,
// m_k written at the end of E9. Expected values below are hand-computed.
module tb_pid_scheduler;

   localparam int AW  = 1;
   localparam int EW  = 24;
   localparam int OW  = 12;
   localparam int OVW = 8;
   localparam int AN  = 2;

   logic              clk_pid = 1'b0;
   logic              reset;
   logic              tick;
   logic [AN-1:0]     ch_enable;
   logic [AN*EW-1:0]  error_flat;
   logic [AW-1:0]     pid_a;
   logic              pid_ce;
   logic              pid_reset;
   logic [EW-1:0]     pid_error;
   logic [OW-1:0]     pid_m_k;
   logic [AN*OW-1:0]  m_k_flat;
   logic [AN-1:0]     m_k_valid;
   logic              busy;
   logic              done;
   logic [OVW-1:0]    overrun_cnt;

   always #5 clk_pid = ~clk_pid;

   pid_scheduler #(.AW(AW), .EW(EW), .OW(OW), .OVW(OVW)) dut (
      .clk_pid     (clk_pid),
      .reset       (reset),
      .tick        (tick),
      .ch_enable   (ch_enable),
      .error_flat  (error_flat),
      .pid_a       (pid_a),
      .pid_ce      (pid_ce),
      .pid_reset   (pid_reset),
      .pid_error   (pid_error),
      .pid_m_k     (pid_m_k),
      .m_k_flat    (m_k_flat),
      .m_k_valid   (m_k_valid),
      .busy        (busy),
      .done        (done),
      .overrun_cnt (overrun_cnt)
   );

   // behavioural PID core
   int                       core_st = 4;
   logic signed [EW-1:0]     core_e;
   logic signed [OW-1:0]     core_m;
   logic signed [OW-1:0]     mem_m [AN];
   logic signed [EW-1:0]     mem_e [AN];

   assign pid_m_k = core_m;

   function automatic logic [OW-1:0] pid_law(input logic signed [OW-1:0] mp,
                                             input logic signed [EW-1:0] ep,
                                             input logic signed [EW-1:0] e);
      int t;
      t = int'(mp) + 3 * int'(e) - int'(ep);
      return t[OW-1:0];
   endfunction

   initial begin
      core_e = '0;
      core_m = '0;
      for (int i = 0; i < AN; i++) begin
         mem_m[i] = '0;
         mem_e[i] = '0;
      end
   end

   always @(posedge clk_pid) begin
      if (pid_ce) begin
         if (pid_reset) begin
            core_st <= 0;
         end else begin
            core_st <= (core_st == 0 || core_st == 10) ? 1 : core_st + 1;
            if (core_st == 1) core_e <= $signed(pid_error);
            if (core_st == 9) begin
               core_m        <= pid_law(mem_m[pid_a], mem_e[pid_a], core_e);
               mem_m[pid_a]  <= pid_law(mem_m[pid_a], mem_e[pid_a], core_e);
               mem_e[pid_a]  <= core_e;
            end
         end
      end
   end

   // checking
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // sweep observation
   int exp_err [AN];
   int first_ce [AN];
   int last_ce [AN];
   int valid_cyc [AN];
   int ce_cnt, done_cyc, err_bad, busy_bad;

   task automatic set_err(input int e0, input int e1);
      error_flat[0  +: EW] = e0[EW-1:0];
      error_flat[EW +: EW] = e1[EW-1:0];
      exp_err[0] = e0;
      exp_err[1] = e1;
   endtask

   // Leaves the bench in the middle of cycle T+1 (tick sampled at end of T).
   task automatic start_tick();
      @(negedge clk_pid);
      tick = 1'b1;
      @(negedge clk_pid);
      tick = 1'b0;
   endtask

   // Records per-cycle activity of one sweep; c is the cycle offset from T.
   // Inputs are scrambled mid-sweep to show that only the snapshot matters.
   task automatic run_sweep(input int xtick_at);
      logic [AN*EW-1:0] saved_err;
      logic [AN-1:0]    saved_en;
      for (int i = 0; i < AN; i++) begin
         first_ce[i]  = -1;
         last_ce[i]   = -1;
         valid_cyc[i] = -1;
      end
      ce_cnt   = 0;
      done_cyc = -1;
      err_bad  = 0;
      busy_bad = 0;
      saved_err = error_flat;
      saved_en  = ch_enable;
      start_tick();
      for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
         if (pid_ce) begin
            ce_cnt++;
            if (first_ce[pid_a] < 0) first_ce[pid_a] = c;
            last_ce[pid_a] = c;
            if (int'($signed(pid_error)) != exp_err[pid_a]) err_bad++;
         end
         for (int i = 0; i < AN; i++)
            if (m_k_valid[i]) valid_cyc[i] = c;
         if (done) begin
            done_cyc = c;
            if (busy) busy_bad++;
         end else if (!busy) begin
            busy_bad++;
         end
         if (c == 3) begin
            error_flat = ~saved_err;
            ch_enable  = ~saved_en;
         end
         tick = (c == xtick_at);
         @(negedge clk_pid);
      end
      tick       = 1'b0;
      error_flat = saved_err;
      ch_enable  = saved_en;
   endtask

   task automatic check_full_sweep(input string t, input int m0, input int m1);
      check_eq({t, "_ce0_first"}, first_ce[0], 2);
      check_eq({t, "_ce0_last"},  last_ce[0], 11);
      check_eq({t, "_ce1_first"}, first_ce[1], 13);
      check_eq({t, "_ce1_last"},  last_ce[1], 22);
      check_eq({t, "_ce_cnt"},    ce_cnt, 20);
      check_eq({t, "_valid0"},    valid_cyc[0], 12);
      check_eq({t, "_valid1"},    valid_cyc[1], 23);
      check_eq({t, "_done"},      done_cyc, 23);
      check_eq({t, "_err_bad"},   err_bad, 0);
      check_eq({t, "_busy_bad"},  busy_bad, 0);
      check_eq({t, "_core_st"},   core_st, 1);
      check_eq({t, "_m0"}, longint'($signed(m_k_flat[0  +: OW])), m0);
      check_eq({t, "_m1"}, longint'($signed(m_k_flat[OW +: OW])), m1);
   endtask

   int storm_ce;

   initial begin
      reset      = 1'b1;
      tick       = 1'b0;
      ch_enable  = '0;
      error_flat = '0;
      exp_err[0] = 0;
      exp_err[1] = 0;

      // reset and INIT sequence
      repeat (3) @(negedge clk_pid);
      reset = 1'b0;
      check_eq("init0_ce",     pid_ce, 1);
      check_eq("init0_rst",    pid_reset, 1);
      check_eq("init0_busy",   busy, 0);
      check_eq("init0_mk",     m_k_flat, 0);
      check_eq("init0_ovr",    overrun_cnt, 0);
      check_eq("init0_done",   done, 0);
      @(negedge clk_pid);
      check_eq("init1_ce",     pid_ce, 1);
      check_eq("init1_rst",    pid_reset, 0);
      @(negedge clk_pid);
      check_eq("idle_ce",      pid_ce, 0);
      check_eq("idle_core_st", core_st, 1);
      check_eq("idle_valid",   m_k_valid, 0);

      // A: both channels, opposite errors
      ch_enable = 2'b11;
      set_err(100, -100);
      run_sweep(0);
      check_full_sweep("a", 300, -300);

      // B: only ch1; ch0 keeps 300
      ch_enable = 2'b10;
      set_err(50, 40);
      run_sweep(0);
      check_eq("b_ce0_first", first_ce[0], -1);
      check_eq("b_ce1_first", first_ce[1], 3);
      check_eq("b_ce1_last",  last_ce[1], 12);
      check_eq("b_ce_cnt",    ce_cnt, 10);
      check_eq("b_valid0",    valid_cyc[0], -1);
      check_eq("b_valid1",    valid_cyc[1], 13);
      check_eq("b_done",      done_cyc, 13);
      check_eq("b_err_bad",   err_bad, 0);
      check_eq("b_m0", longint'($signed(m_k_flat[0  +: OW])), 300);
      check_eq("b_m1", longint'($signed(m_k_flat[OW +: OW])), -80);

      // C: nothing enabled
      ch_enable = 2'b00;
      set_err(9, 9);
      run_sweep(0);
      check_eq("c_ce_cnt",  ce_cnt, 0);
      check_eq("c_valid0",  valid_cyc[0], -1);
      check_eq("c_valid1",  valid_cyc[1], -1);
      check_eq("c_done",    done_cyc, 3);
      check_eq("c_busy_bad", busy_bad, 0);
      check_eq("c_mk", m_k_flat, {12'hFB0, 12'd300});

      // D: second tick at T+5 is rejected and counted
      ch_enable = 2'b11;
      set_err(10, 20);
      run_sweep(5);
      check_full_sweep("d", 230, -60);
      check_eq("d_ovr", overrun_cnt, 1);

      // tick storm with no channels enabled: counter must saturate
      ch_enable = 2'b00;
      storm_ce  = 0;
      tick      = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_pid);
         if (pid_ce) storm_ce++;
      end
      tick = 1'b0;
      repeat (5) @(negedge clk_pid);
      check_eq("storm_ovr",  overrun_cnt, 255);
      check_eq("storm_ce",   storm_ce, 0);
      check_eq("storm_busy", busy, 0);
      check_eq("storm_mk",   m_k_flat, {12'hFC4, 12'd230});

      // E: reset during ch0 RUN step 4; ticks during INIT are dropped
      ch_enable = 2'b11;
      set_err(7, 9);
      start_tick();
      repeat (5) @(negedge clk_pid);
      check_eq("e_run_ce", pid_ce, 1);
      check_eq("e_run_a",  pid_a, 0);
      reset = 1'b1;
      @(negedge clk_pid);
      reset = 1'b0;
      tick  = 1'b1;
      check_eq("e_init0_ce",  pid_ce, 1);
      check_eq("e_init0_rst", pid_reset, 1);
      check_eq("e_init0_mk",  m_k_flat, 0);
      check_eq("e_init0_ovr", overrun_cnt, 0);
      @(negedge clk_pid);
      check_eq("e_init1_ce",  pid_ce, 1);
      check_eq("e_init1_rst", pid_reset, 0);
      tick = 1'b0;
      @(negedge clk_pid);
      check_eq("e_idle_ce",   pid_ce, 0);
      check_eq("e_idle_busy", busy, 0);
      check_eq("e_idle_ovr",  overrun_cnt, 0);
      check_eq("e_core_st",   core_st, 1);

      // F: normal sweep after the interrupted one, core still aligned
      set_err(-20, 30);
      run_sweep(0);
      check_full_sweep("f", 160, 10);
      check_eq("f_ovr", overrun_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pid_scheduler.md
Name: pid_scheduler

Overview:
- Sequences a shared, time-multiplexed discrete PID core (10-state iteration E1..E10, per-channel memory selected by address `a`).
- On each control-loop tick it snapshots all channel errors, then runs one full PID iteration for each enabled channel in ascending address order.
- It drives the core's address, clock-enable, reset and error inputs, and captures each channel's motor output into a flat output bus.
- Sits between the encoder/setpoint error logic and the PWM generators.

Parameters:
- AW, 1: address width; AN = 2^AW channels.
- EW, 24: error width per channel.
- OW, 12: motor output width per channel.
- OVW, 8: overrun counter width.

Ports:
- clk_pid  in  1  clock; the same clock as the PID core.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  single-cycle control-loop strobe (fixed 2^fp Hz).
- ch_enable  in  AN  per-channel enable mask, sampled when a tick is accepted.
- error_flat  in  AN*EW  signed errors; channel i occupies bits [i*EW +: EW].
- pid_a  out  AW  address to the PID core.
- pid_ce  out  1  clock enable to the PID core.
- pid_reset  out  1  reset to the PID core; only effective while pid_ce=1.
- pid_error  out  EW  error to the PID core, taken from the snapshot slice at pid_a.
- pid_m_k  in  OW  m_k_out from the PID core.
- m_k_flat  out  AN*OW  captured signed outputs; channel i occupies bits [i*OW +: OW].
- m_k_valid  out  AN  one-cycle pulse per channel when its output is updated.
- busy  out  1  high in SCAN and RUN.
- done  out  1  one-cycle pulse at the end of a sweep.
- overrun_cnt  out  OVW  saturating count of rejected ticks.

Behaviour:
- Reset values: all outputs 0 except as noted; m_k_flat=0, err_snap=0, mask_snap=0, overrun_cnt=0; state=INIT0.
- States:
  - INIT0: pid_ce=1, pid_reset=1, forcing the core to E0. Next state INIT1.
  - INIT1: pid_ce=1, pid_reset=0, moving the core E0->E1. Next state IDLE.
  - IDLE: pid_ce=0. On tick: err_snap<=error_flat, mask_snap<=ch_enable, idx<=0, next state SCAN.
  - SCAN: pid_ce=0.
    - If mask_snap[idx]=1: step<=0, next state RUN.
    - Otherwise, if idx==AN-1: next state DONE.
    - Otherwise: idx<=idx+1, stay in SCAN. Each disabled channel costs 1 cycle.
  - RUN: pid_ce=1 and step counts 0..9. Step k corresponds to core state E(k+1).
    - The core latches pid_error during step 0 and writes m_k at the end of step 8.
    - At the end of step 9: m_k_flat[idx] <= pid_m_k, and m_k_valid[idx] is high in the following cycle.
    - After step 9: if idx==AN-1, next state DONE; otherwise idx<=idx+1, next state SCAN.
  - DONE: done=1 for exactly 1 cycle, then IDLE.
- pid_a is registered from idx and is stable for the whole RUN. pid_ce is never high outside INIT0, INIT1 and RUN, so the core only leaves E1 within a RUN and always returns to E1 at RUN end.
- Tick acceptance:
  - Ticks are accepted only in IDLE.
  - A tick in SCAN, RUN or DONE increments overrun_cnt, saturating at all-ones, and is otherwise ignored.
  - A tick in INIT0 or INIT1 is dropped and not counted.
- Sweep latency with all channels enabled, tick seen in IDLE at cycle T:
  - Channel i is in RUN for cycles T+2+11i .. T+11+11i.
  - m_k_valid[i] fires at T+12+11i.
  - DONE is at T+1+11*AN.
- ch_enable=0 at tick: SCAN walks all AN indices (AN cycles), then DONE. No pid_ce, no m_k_valid.
- Changes to error_flat or ch_enable mid-sweep have no effect until the next accepted tick.
- Disabled channels keep their previous m_k_flat value.
- Reset asserted in any state, including mid-RUN: next state INIT0. The INIT sequence realigns the core to E1 and all captured outputs clear.

Test Plan:
- Reset, then release -> pid_ce=1 for 2 cycles with pid_reset=1 only in the first; core reaches E1; busy=0, m_k_flat=0.
- AN=2, all channels enabled, error_flat={ch1=-100, ch0=+100}, tick at T -> ch0 RUN T+2..T+11 with pid_error=100; m_k_valid=01 at T+12; ch1 RUN T+13..T+22 with pid_error=-100; m_k_valid=10 at T+23; done at T+23.
- ch_enable=10 -> ch0 skipped in 1 SCAN cycle; only ch1 runs (pid_a=1 throughout RUN); m_k_flat ch0 unchanged; done 13 cycles after tick.
- ch_enable=00, tick -> no pid_ce; done 3 cycles after tick.
- Ticks at T and T+5, then 300 ticks during busy -> overrun_cnt = 1, then saturates at 255; the first sweep completes unaffected.
- Reset asserted at RUN step 4 of ch0 -> INIT0/INIT1 sequence, m_k_flat=0; the next tick produces a normal sweep with correct core alignment (m_k matches the golden PID model).
